// File: rtl/sha_core_arbiter.sv
// Round-robin sequencer sharing one SHA-256 core among NUM_REQ hash clients.
// Optional WAIT-state watchdog is compiled in when SHA_ARB_TIMEOUT_EN is defined.
module sha_core_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*512-1:0] req_block,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     done,
  output logic [NUM_REQ-1:0]     timeout_err,
  output logic [255:0]           digest,
  output logic                   busy,
  output logic                   sha_init,
  output logic                   sha_reset_n,
  output logic [511:0]           sha_block,
  input  logic                   sha_ready,
  input  logic [255:0]           sha_digest,
  input  logic                   sha_digest_valid
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT,
    ST_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [PTR_W-1:0]   winner;
  logic               winner_found;
  logic [511:0]       winner_block;
  logic [NUM_REQ-1:0] winner_onehot;
  logic [NUM_REQ-1:0] owner_onehot;
  logic [NUM_REQ-1:0] grant_d, done_d, timeout_err_d;
  logic [255:0]       digest_d;
  logic [511:0]       sha_block_d;
  logic               busy_d, sha_init_d, sha_reset_n_d;
  logic               finish_job;
  logic               timeout_hit;

  if (NUM_REQ < 2) begin : g_chk_num_req
    $error("sha_core_arbiter: NUM_REQ must be at least 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_chk_timeout
    $error("sha_core_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  // Round-robin search: first requester after the last served client.
  always_comb begin : p_search
    logic [PTR_W:0] target;
    winner       = rr_ptr_q;
    winner_found = 1'b0;
    target       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      target = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (target >= (PTR_W+1)'(NUM_REQ)) begin
        target = target - (PTR_W+1)'(NUM_REQ);
      end
      for (int c = 0; c < NUM_REQ; c++) begin
        if (!winner_found && req[c] && (target == (PTR_W+1)'(c))) begin
          winner       = PTR_W'(c);
          winner_found = 1'b1;
        end
      end
    end
  end

  always_comb begin : p_select
    winner_block  = '0;
    winner_onehot = '0;
    owner_onehot  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PTR_W'(i)) begin
        winner_block     = req_block[i*512 +: 512];
        winner_onehot[i] = 1'b1;
      end
      if (owner_q == PTR_W'(i)) begin
        owner_onehot[i] = 1'b1;
      end
    end
  end

`ifdef SHA_ARB_TIMEOUT_EN
  logic [31:0] wait_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  assign timeout_hit = (state_q == ST_WAIT) && !sha_digest_valid &&
                       (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin : p_next
    // NOTE: every next-value gets a default first, so no branch can leave one unassigned and infer a latch.
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    grant_d       = grant;
    done_d        = '0;
    timeout_err_d = '0;
    digest_d      = digest;
    sha_init_d    = 1'b0;
    sha_reset_n_d = sha_reset_n;
    sha_block_d   = sha_block;
    finish_job    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (winner_found && sha_ready && !sha_digest_valid) begin
          owner_d       = winner;
          grant_d       = winner_onehot;
          sha_block_d   = winner_block;
          sha_reset_n_d = 1'b1;
          sha_init_d    = 1'b1;
          state_d       = ST_INIT;
        end
      end
      ST_INIT: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sha_digest_valid) begin
          digest_d   = sha_digest;
          finish_job = 1'b1;
        end else if (timeout_hit) begin
          timeout_err_d = owner_onehot;
          finish_job    = 1'b1;
        end
        // The core goes back into reset as soon as the job ends.
        if (finish_job) begin
          done_d        = owner_onehot;
          grant_d       = '0;
          sha_reset_n_d = 1'b0;
          sha_block_d   = '0;
          rr_ptr_d      = owner_q;
          state_d       = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != ST_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= PTR_W'(NUM_REQ - 1);
      owner_q     <= '0;
      grant       <= '0;
      done        <= '0;
      timeout_err <= '0;
      // NOTE: the wide block/digest registers are reset on purpose: the core bus must read 0 when idle.
      digest      <= '0;
      sha_block   <= '0;
      busy        <= 1'b0;
      sha_init    <= 1'b0;
      sha_reset_n <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      grant       <= grant_d;
      done        <= done_d;
      timeout_err <= timeout_err_d;
      digest      <= digest_d;
      sha_block   <= sha_block_d;
      busy        <= busy_d;
      sha_init    <= sha_init_d;
      sha_reset_n <= sha_reset_n_d;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(grant));
  a_init_in_job: assert property (@(posedge clk) disable iff (!reset_n)
    sha_init |-> (|grant));
  a_done_pulse: assert property (@(posedge clk) disable iff (!reset_n)
    (|done) |=> !(|done));
  a_err_with_done: assert property (@(posedge clk) disable iff (!reset_n)
    (timeout_err & ~done) == '0);

endmodule

// File: tb/tb_sha_core_arbiter.sv
// Bench for sha_core_arbiter: fake SHA core, job-level reference model checked every cycle,
// and directed scenarios with hand-computed expectations. Honours SHA_ARB_TIMEOUT_EN.
module tb_sha_core_arbiter;

  localparam int NUM_REQ   = 2;
  localparam int TO_CYCLES = 16;
  localparam int CORE_LAT  = 65;
`ifdef SHA_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  localparam logic [511:0] BLK_A = {16{32'h0123_4567}};
  localparam logic [511:0] BLK_B = {16{32'h89ab_cdef}};
  localparam logic [511:0] BLK_C = {8{64'hdead_beef_0bad_f00d}};

  logic                   clk;
  logic                   reset_n;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*512-1:0] req_block;
  logic [NUM_REQ-1:0]     grant;
  logic [NUM_REQ-1:0]     done;
  logic [NUM_REQ-1:0]     timeout_err;
  logic [255:0]           digest;
  logic                   busy;
  logic                   sha_init;
  logic                   sha_reset_n;
  logic [511:0]           sha_block;
  logic                   sha_ready;
  logic [255:0]           sha_digest;
  logic                   sha_digest_valid;

  int checks   = 0;
  int failures = 0;
  logic force_valid = 1'b0;
  logic core_hang   = 1'b0;

  sha_core_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CYCLES(TO_CYCLES)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .req              (req),
    .req_block        (req_block),
    .grant            (grant),
    .done             (done),
    .timeout_err      (timeout_err),
    .digest           (digest),
    .busy             (busy),
    .sha_init         (sha_init),
    .sha_reset_n      (sha_reset_n),
    .sha_block        (sha_block),
    .sha_ready        (sha_ready),
    .sha_digest       (sha_digest),
    .sha_digest_valid (sha_digest_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [255:0] fake_hash(input logic [511:0] b);
    return b[511:256] ^ {b[127:0], b[255:128]} ^ {8{32'h6a09_e667}};
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Stand-in SHA core: result CORE_LAT cycles after sha_init unless hung.
  initial begin : core_model
    int cnt;
    logic running;
    logic [511:0] held;
    cnt = 0;
    running = 1'b0;
    held = '0;
    sha_ready = 1'b1;
    sha_digest_valid = 1'b0;
    sha_digest = '0;
    forever begin
      @(posedge clk);
      #1;
      sha_digest_valid = force_valid;
      if (!reset_n || !sha_reset_n) begin
        running   = 1'b0;
        sha_ready = 1'b1;
      end else if (running) begin
        cnt++;
        if (cnt == CORE_LAT && !core_hang) begin
          sha_digest       = fake_hash(held);
          sha_digest_valid = 1'b1;
          running          = 1'b0;
          sha_ready        = 1'b1;
        end
      end else if (sha_init) begin
        running   = 1'b1;
        cnt       = 0;
        held      = sha_block;
        sha_ready = 1'b0;
      end
    end
  end

  // Job-level reference model, compared against the DUT on every falling edge.
  initial begin : scoreboard
    bit active, finishing, timed_out, found;
    int owner, age, rr, c;
    logic [511:0] blk;
    logic [255:0] dig;
    logic [NUM_REQ-1:0] own;
    active = 0; finishing = 0; timed_out = 0; found = 0;
    owner = 0; age = 0; rr = NUM_REQ - 1; c = 0;
    blk = '0; dig = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        active = 0; finishing = 0; timed_out = 0;
        owner = 0; age = 0; rr = NUM_REQ - 1;
        blk = '0; dig = '0;
      end
      own = NUM_REQ'(1) << owner;
      check("m_grant",       512'(grant),       512'(active ? own : '0));
      check("m_done",        512'(done),        512'(finishing ? own : '0));
      check("m_timeout_err", 512'(timeout_err), 512'((finishing && timed_out) ? own : '0));
      check("m_digest",      512'(digest),      512'(dig));
      check("m_busy",        512'(busy),        512'(active || finishing));
      check("m_sha_init",    512'(sha_init),    512'(active && age == 0));
      check("m_sha_reset_n", 512'(sha_reset_n), 512'(active));
      check("m_sha_block",   sha_block,         active ? blk : '0);
      if (reset_n) begin
        if (finishing) begin
          finishing = 0;
          timed_out = 0;
        end else if (active) begin
          if (age >= 1 && sha_digest_valid) begin
            dig = sha_digest;
            active = 0; finishing = 1; rr = owner;
          end else if (TIMEOUT_ON && age == TO_CYCLES) begin
            timed_out = 1;
            active = 0; finishing = 1; rr = owner;
          end else begin
            age++;
          end
        end else if (req != '0 && sha_ready && !sha_digest_valid) begin
          found = 0;
          for (int k = 1; k <= NUM_REQ; k++) begin
            c = (rr + k) % NUM_REQ;
            if (!found && ((req >> c) & NUM_REQ'(1)) != '0) begin
              found = 1;
              owner = c;
            end
          end
          active = 1;
          age = 0;
          blk = 512'(req_block >> (owner * 512));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (grant != '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int budget, output bit ok, output int cycles);
    ok = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done != '0) begin
        ok = 1'b1;
        cycles = i + 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    step();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin : stimulus
    bit ok;
    int n, hold_cnt, grant_cnt, done_cnt;
    logic [NUM_REQ-1:0] exp_seq [4];
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    req = '0;
    req_block = {BLK_B, BLK_A};
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    step(); step();
    @(negedge clk);
    check("rst_grant",       512'(grant),       512'(0));
    check("rst_sha_reset_n", 512'(sha_reset_n), 512'(0));
    check("rst_busy",        512'(busy),        512'(0));
    check("rst_digest",      512'(digest),      512'(0));
    check("rst_sha_block",   sha_block,         '0);
    step();
    reset_n = 1'b1;

    // 1: single client job
    step();
    req = 2'b01;
    wait_grant(10, ok);
    check("t1_grant_seen", 512'(ok), 512'(1));
    check("t1_grant",      512'(grant),    512'(2'b01));
    check("t1_sha_init",   512'(sha_init), 512'(1));
    check("t1_sha_block",  sha_block, BLK_A);
    @(negedge clk);
    check("t1_init_low",   512'(sha_init), 512'(0));
    wait_done(200, ok, n);
    check("t1_done_seen",  512'(ok), 512'(1));
    check("t1_done",       512'(done),   512'(2'b01));
    check("t1_digest",     512'(digest), 512'(fake_hash(BLK_A)));
    step();
    req = '0;
    @(negedge clk);
    check("t1_done_pulse", 512'(done), 512'(0));

    // 2: both clients held high from reset
    do_reset();
    req = 2'b11;
    for (int j = 0; j < 4; j++) begin
      wait_grant(20, ok);
      check("t2_grant_seen", 512'(ok), 512'(1));
      check("t2_grant",      512'(grant), 512'(exp_seq[j]));
      wait_done(200, ok, n);
      check("t2_done_seen",  512'(ok), 512'(1));
      check("t2_done",       512'(done), 512'(exp_seq[j]));
      check("t2_digest",     512'(digest), 512'(fake_hash((j % 2 == 1) ? BLK_B : BLK_A)));
    end
    step();
    req = '0;

    // 3: stray digest_valid in IDLE blocks arbitration
    step();
    force_valid = 1'b1;
    step();
    req = 2'b01;
    grant_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (grant != '0) grant_cnt++;
    end
    check("t3_no_grant",  512'(grant_cnt), 512'(0));
    check("t3_digest",    512'(digest), 512'(fake_hash(BLK_B)));
    step();
    force_valid = 1'b0;
    wait_grant(10, ok);
    check("t3_grant_seen", 512'(ok), 512'(1));
    wait_done(200, ok, n);
    check("t3_done",      512'(done), 512'(2'b01));
    step();
    req = '0;

    // 4: block change and req drop after grant
    step();
    req = 2'b01;
    wait_grant(10, ok);
    check("t4_grant_seen", 512'(ok), 512'(1));
    step();
    req_block[511:0] = BLK_C;
    req = '0;
    @(negedge clk);
    check("t4_block_held", sha_block, BLK_A);
    wait_done(200, ok, n);
    check("t4_done_seen", 512'(ok), 512'(1));
    check("t4_done",      512'(done),   512'(2'b01));
    check("t4_digest",    512'(digest), 512'(fake_hash(BLK_A)));
    req_block[511:0] = BLK_A;

    // 5: reset during WAIT
    step();
    req = 2'b01;
    wait_grant(10, ok);
    repeat (10) @(negedge clk);
    step();
    reset_n = 1'b0;
    #1;
    check("t5_grant",       512'(grant),       512'(0));
    check("t5_busy",        512'(busy),        512'(0));
    check("t5_sha_reset_n", 512'(sha_reset_n), 512'(0));
    check("t5_sha_block",   sha_block,         '0);
    check("t5_digest",      512'(digest),      512'(0));
    req = 2'b11;
    step();
    step();
    reset_n = 1'b1;
    wait_grant(10, ok);
    check("t5_grant_seen",  512'(ok), 512'(1));
    check("t5_first_grant", 512'(grant), 512'(2'b01));
    wait_done(200, ok, n);
    check("t5_done",        512'(done), 512'(2'b01));
    step();
    req = '0;

    // 6: hung core
    step();
    core_hang = 1'b1;
    req = 2'b01;
    wait_grant(10, ok);
    check("t6_grant_seen", 512'(ok), 512'(1));
`ifdef SHA_ARB_TIMEOUT_EN
    wait_done(TO_CYCLES + 10, ok, n);
    check("t6_done_seen",   512'(ok), 512'(1));
    check("t6_latency",     512'(n), 512'(TO_CYCLES + 1));
    check("t6_done",        512'(done),        512'(2'b01));
    check("t6_timeout_err", 512'(timeout_err), 512'(2'b01));
    check("t6_digest",      512'(digest), 512'(fake_hash(BLK_A)));
    step();
    req = '0;
    core_hang = 1'b0;
`else
    hold_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (busy) hold_cnt++;
      if (done != '0) done_cnt++;
    end
    check("t6_busy_hold", 512'(hold_cnt), 512'(1000));
    check("t6_no_done",   512'(done_cnt), 512'(0));
    check("t6_no_err",    512'(timeout_err), 512'(0));
    req = '0;
    core_hang = 1'b0;
    do_reset();
`endif
    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
